// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline register and register-file write-back driver.
//
// Holds one MEM-stage result. Load data is extracted and sign/zero-extended
// when the entry is captured, so the write-back side only sees a ready word.
// The register-file write port is driven straight from the held payload.
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   flush                      kill held entry, refuse this cycle's input
//   mem_valid / mem_ready      upstream handshake (mem_ready is combinational)
//   mem_regwrite, mem_memtoreg, mem_loadtype, mem_byteoff,
//   mem_writeadr, mem_aluresult, mem_readdata   MEM-stage payload
//   wb_hold                    register-file port busy, keep current entry
//   RegWrite, writeadr, WriteData   register-file write port
//   retire_count               retired register-writing entries (wraps)
//
// Optional feature (macro WB_BYPASS_EN): adds fwd_valid / fwd_adr / fwd_data,
// a forwarding view of the held entry for the EX stage.
module mem_wb_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_regwrite,
  input  logic             mem_memtoreg,
  input  logic [2:0]       mem_loadtype,
  input  logic [1:0]       mem_byteoff,
  input  logic [AW-1:0]    mem_writeadr,
  input  logic [DW-1:0]    mem_aluresult,
  input  logic [DW-1:0]    mem_readdata,
  input  logic             wb_hold,
  output logic             RegWrite,
  output logic [AW-1:0]    writeadr,
  output logic [DW-1:0]    WriteData,
  output logic [CNT_W-1:0] retire_count
`ifdef WB_BYPASS_EN
  ,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_adr,
  output logic [DW-1:0]    fwd_data
`endif
);

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic             valid_reg;
  logic             valid_next;
  logic             regwrite_reg;
  logic [AW-1:0]    writeadr_reg;
  logic [DW-1:0]    writedata_reg;
  logic [DW-1:0]    writedata_next;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic             retire;
  logic             count_inc;

  // Byte lanes of the raw memory word, selected by the byte offset.
  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [DW-1:0] load_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = mem_readdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[mem_byteoff];
  // Halfword alignment uses only byteoff[1].
  assign half_sel = mem_byteoff[1] ? mem_readdata[31:16] : mem_readdata[15:0];

  always_comb begin
    load_ext = mem_readdata;
    case (mem_loadtype)
      LT_LH:   load_ext = {{(DW-16){half_sel[15]}}, half_sel};
      LT_LHU:  load_ext = {{(DW-16){1'b0}}, half_sel};
      LT_LB:   load_ext = {{(DW-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  load_ext = {{(DW-8){1'b0}}, byte_sel};
      default: load_ext = mem_readdata;   // lw and undefined encodings
    endcase
  end

  assign writedata_next = mem_memtoreg ? load_ext : mem_aluresult;

  // Handshake. Ready ignores flush; flush only blocks the accept itself.
  assign mem_ready = !valid_reg || !wb_hold;
  assign accept    = mem_valid && mem_ready && !flush;
  // A flushed entry neither writes nor counts as retired.
  assign retire    = valid_reg && !wb_hold && !flush;
  assign count_inc = retire && regwrite_reg;

  always_comb begin
    valid_next = valid_reg;
    if (flush)       valid_next = 1'b0;
    else if (accept) valid_next = 1'b1;
    else if (retire) valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      writeadr_reg  <= '0;
      writedata_reg <= '0;
      count_reg     <= '0;
    end else begin
      valid_reg <= valid_next;
      // Payload only moves on accept so the write port holds while idle.
      if (accept) begin
        regwrite_reg  <= mem_regwrite;
        writeadr_reg  <= mem_writeadr;
        writedata_reg <= writedata_next;
      end
      if (count_inc) count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Writes to $0 never reach the register file. Reset also gates the
  // strobe so a held entry is dropped without a write.
  assign RegWrite     = retire && regwrite_reg && (writeadr_reg != '0) && !reset;
  assign writeadr     = writeadr_reg;
  assign WriteData    = writedata_reg;
  assign retire_count = count_reg;

`ifdef WB_BYPASS_EN
  // Forwarding stays visible while the write is stalled by wb_hold.
  assign fwd_valid = valid_reg && regwrite_reg && (writeadr_reg != '0) && !flush;
  assign fwd_adr   = writeadr_reg;
  assign fwd_data  = writedata_reg;
`endif

endmodule
